// File: rtl/tholin_counter_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment counter.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package tholin_counter_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam int TICK_DIV_DEFAULT = 1000;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_MAX  = 4'd9;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes blank the digit.
module bcd_to_7seg
    import tholin_counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tholin_multiplexed_counter.sv
// Free-running 00..99 decimal counter time-multiplexed onto one segment bus.
// Clock and synchronous reset arrive on io_in[0] and io_in[1].
module tholin_multiplexed_counter
    import tholin_counter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic        clk;
    logic        rst;
    logic        unused_io_bits;

    logic [15:0] prescaler;
    bcd_t        ones;
    bcd_t        tens;
    logic        sel;

    bcd_t        digit;
    seg_t        seg;

    assign clk            = io_in[0];
    assign rst            = io_in[1];
    assign unused_io_bits = ^io_in[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            ones      <= BCD_ZERO;
            tens      <= BCD_ZERO;
            sel       <= 1'b0;
        end else begin
            sel <= ~sel;
            if (prescaler == TICK_LAST) begin
                prescaler <= '0;
                if (ones == BCD_MAX) begin
                    ones <= BCD_ZERO;
                    // 99 rolls straight back to 00 with no carry-out
                    tens <= (tens == BCD_MAX) ? BCD_ZERO : tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end else begin
                prescaler <= prescaler + 16'd1;
            end
        end
    end

    assign digit = sel ? tens : ones;

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (seg)
    );

    assign io_out = {sel, seg};

endmodule

// File: tb/tb_tholin_multiplexed_counter.sv
// Directed bench: three counter instances (TICK_DIV 4, 1, 2) on a shared clock.
module tb_tholin_multiplexed_counter;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_bc = 1'b1;
    logic [5:0] junk = 6'd0;

    logic [7:0] io_in_a, io_in_bc;
    logic [7:0] out_a, out_b, out_c;

    int n_checks = 0;
    int n_errors = 0;
    int na = 0;
    int nb = 0;

    assign io_in_a  = {junk, rst_a, clk};
    assign io_in_bc = {~junk, rst_bc, clk};

    always #5 clk = ~clk;

    tholin_multiplexed_counter #(.TICK_DIV(4)) u_a (.io_in(io_in_a),  .io_out(out_a));
    tholin_multiplexed_counter #(.TICK_DIV(1)) u_b (.io_in(io_in_bc), .io_out(out_b));
    tholin_multiplexed_counter #(.TICK_DIV(2)) u_c (.io_in(io_in_bc), .io_out(out_c));

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected display n edges after reset release for a given divider.
    function automatic logic [7:0] model(input int n, input int td);
        int  cnt;
        bit  s;
        cnt = (n / td) % 100;
        s   = (n % 2) == 1;
        return {s, seg_of(s ? cnt / 10 : cnt % 10)};
    endfunction

    task automatic tick();
        bit ra, rb;
        ra = rst_a;
        rb = rst_bc;
        @(posedge clk);
        #1;
        na = ra ? 0 : na + 1;
        nb = rb ? 0 : nb + 1;
        check_val("model_a", out_a, model(na, 4));
        check_val("model_b", out_b, model(nb, 1));
        check_val("model_c", out_c, model(nb, 2));
        junk = 6'($urandom);
    endtask

    initial begin
        #2;
        tick();
        tick();
        check_val("rst_a", out_a, 8'h3F);
        check_val("rst_b", out_b, 8'h3F);
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        tick();
        check_val("sel_first_tens", out_a, 8'hBF);
        tick();
        check_val("sel_back_ones", out_a, 8'h3F);
        tick();
        check_val("pre3_tens", out_a, 8'hBF);
        tick();
        check_val("pre4_one", out_a, 8'h06);
        while (na < 8) tick();
        check_val("pre8_two", out_a, 8'h5B);

        while (nb < 20) tick();
        check_val("c10_ones", out_c, 8'h3F);
        tick();
        check_val("c10_tens", out_c, 8'h86);
        check_val("b21_tens", out_b, 8'hDB);

        while (na < 149) tick();
        check_val("a37_tens", out_a, 8'hCF);
        rst_a = 1'b1;
        tick();
        check_val("mid_rst", out_a, 8'h3F);
        rst_a = 1'b0;
        tick();
        tick();
        tick();
        check_val("resume3", out_a, 8'hBF);
        tick();
        check_val("resume4", out_a, 8'h06);

        while (nb < 198) tick();
        check_val("c99_ones", out_c, 8'h6F);
        tick();
        check_val("c99_tens", out_c, 8'hEF);
        check_val("b99_tens", out_b, 8'hEF);
        tick();
        check_val("c00_ones", out_c, 8'h3F);
        check_val("b00_ones", out_b, 8'h3F);
        tick();
        check_val("c00_tens", out_c, 8'hBF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tholin_multiplexed_counter.md
Name: tholin_multiplexed_counter

Overview:
- Free-running two-digit decimal counter (00–99) driving two common-segment 7-segment digits through one shared 7-bit segment bus plus a digit-select line.
- TinyTapeout-2 style user block: 8-bit packed input and output buses, with clock and reset carried on input bits.
- Sits directly on the chip's user I/O; no other on-chip consumers.

Parameters:
- TICK_DIV, default 1000: clock cycles per count increment; legal range 1..65535.

Ports:
- io_in  input   8  packed input bus:
  - io_in[0] is the clock (rising edge).
  - io_in[1] is the reset, synchronous active-high.
  - io_in[7:2] unused and ignored.
- io_out output  8  packed output bus:
  - io_out[6:0] = segment lines {g,f,e,d,c,b,a}: bit0 = a … bit6 = g, active-high.
  - io_out[7] = SEL digit select: 0 = ones digit, 1 = tens digit.
- One clock (io_in[0]); reset io_in[1] is synchronous and active-high.

Behaviour:
- State registers:
  - prescaler, 16 bits.
  - ones BCD, 4 bits.
  - tens BCD, 4 bits.
  - sel, 1 bit.
- Reset (io_in[1]=1 at a rising edge) has priority over everything else: prescaler=0, ones=0, tens=0, sel=0.
  - Output after reset: io_out = 8'h3F ("0" on the ones digit, SEL=0).
- sel toggles on every non-reset rising edge, so each digit is shown for one clock and the mux rate is clk/2.
- Prescaler, per non-reset edge:
  - If prescaler == TICK_DIV-1: prescaler←0 and the count increments.
  - Otherwise: prescaler←prescaler+1.
  - TICK_DIV=1 means the count increments every clock.
- Count increment (decimal):
  - ones<9 → ones+1.
  - ones==9 → ones←0 and tens increments.
  - tens==9 with ones==9 → wraps to 00. No carry-out; no overflow flag.
- First increment: the count reads 01 immediately after the TICK_DIV-th rising edge following reset release.
- Output is combinational from registered state; no extra latency:
  - io_out[7] = sel.
  - io_out[6:0] = seg(sel ? tens : ones).
- Segment table (hex of io_out[6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - BCD codes 10–15 are unreachable; they decode to 00 (blank).
- Leading zero on the tens digit is displayed, not blanked.
- Reset asserted mid-count: the next edge forces the state to 00 with SEL=0, regardless of prescaler phase.
- A count increment and a sel toggle on the same edge both take effect; the newly selected digit shows the updated value.
- Unused io_in bits have no effect on any state.

Decomposition:
- Shared package tholin_counter_pkg:
  - Segment-pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - BCD digit typedef (4-bit).
  - Default-TICK_DIV constant.
- One natural sub-module: bcd_to_7seg, a purely combinational 4-bit BCD in → 7-bit segments out decoder, instantiated once after the digit mux.
- Prescaler and BCD counter stay in the top.

Test Plan:
- Reset (TICK_DIV=4): hold io_in[1]=1 for 2 edges, release → io_out=8'h3F; on the next edge io_out=8'hBF (SEL=1, tens "0").
- Mux: after reset, over 6 edges io_out[7] alternates 0,1,0,1,0,1; segments alternate ones/tens patterns.
- Prescale (TICK_DIV=4): ones shows 06 ("1") exactly after the 4th post-reset edge, 5B ("2") after the 8th.
- Decimal carry (TICK_DIV=1): after 10 increments the ones digit = 3F and the tens digit = 06 (count 10); digits never show hex codes.
- Wrap (TICK_DIV=1): after 99 increments both digits show 6F; after 100 both show 3F (count 00).
- Mid-run reset: assert io_in[1] at count 37 with prescaler mid-phase → next edge io_out=8'h3F; counting resumes with a full TICK_DIV period; toggling io_in[7:2] changes nothing.
